// File: rtl/route_xy_stage.sv
// route_xy_stage
// Registered XY route-compute stage for one input port of the cardinal mesh
// router. Each accepted packet is routed X-first (E/W, then N/S, then PE), its
// consumed hop field is advanced, and it is held in a two-entry skid buffer
// (main entry drives the outputs, skid entry absorbs one extra packet when the
// downstream stalls) so in_ready can be a pure register-derived signal.

module route_xy_stage #(
  parameter int DATA_W  = 64,
  parameter int HOP_W   = 4,
  parameter int DX_BIT  = 62,
  parameter int DY_BIT  = 61,
  parameter int HX_LSB  = 52,
  parameter int HY_LSB  = 48,
  parameter int HOP_ENC = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [4:0]        out_req,
  output logic              err_hop,
  input  logic              err_clr
);

  // One-hot request encodings, bit order {pe,w,e,s,n}
  localparam logic [4:0] REQ_N  = 5'b00001;
  localparam logic [4:0] REQ_S  = 5'b00010;
  localparam logic [4:0] REQ_E  = 5'b00100;
  localparam logic [4:0] REQ_W  = 5'b01000;
  localparam logic [4:0] REQ_PE = 5'b10000;

  // Buffer occupancy: nothing held, main entry only, or main plus skid entry
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_MAIN  = 2'd1,
    OCC_BOTH  = 2'd2
  } occ_t;

  occ_t occ_q, occ_d;

  logic [HOP_W-1:0]  hx, hy;
  logic [DATA_W-1:0] routed_data;
  logic [4:0]        routed_req;
  logic              hop_bad;

  logic              accept, drain;
  logic              load_main_from_in, load_main_from_skid, load_skid;

  logic [DATA_W-1:0] main_data, skid_data;
  logic [4:0]        main_req, skid_req;

  // A thermometer hop count is a run of ones from bit 0 upward (2^k-1);
  // adding one to such a value clears every bit it had set.
  function automatic logic is_therm(input logic [HOP_W-1:0] v);
    logic [HOP_W-1:0] inc;
    inc = v + HOP_W'(1);
    return (v & inc) == '0;
  endfunction

  // Advance a nonzero hop field by one hop in the configured encoding
  function automatic logic [HOP_W-1:0] hop_next(input logic [HOP_W-1:0] v);
    if (HOP_ENC == 0) return v >> 1;
    else              return v - HOP_W'(1);
  endfunction

  assign hx = in_data[HX_LSB +: HOP_W];
  assign hy = in_data[HY_LSB +: HOP_W];

  // Malformed headers only exist in thermometer mode; binary counts are always legal
  assign hop_bad = (HOP_ENC == 0) && (!is_therm(hx) || !is_therm(hy));

  // Route decision and hop update for the packet currently on the input
  always_comb begin
    routed_data = in_data;
    routed_req  = REQ_PE;
    if (hx != '0) begin
      routed_req                      = in_data[DX_BIT] ? REQ_W : REQ_E;
      routed_data[HX_LSB +: HOP_W]    = hop_next(hx);
    end else if (hy != '0) begin
      routed_req                      = in_data[DY_BIT] ? REQ_S : REQ_N;
      routed_data[HY_LSB +: HOP_W]    = hop_next(hy);
    end
  end

  assign accept = in_valid & in_ready;
  assign drain  = out_valid & out_ready;

  // Occupancy state register; reset discards whatever is buffered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) occ_q <= OCC_EMPTY;
    else       occ_q <= occ_d;
  end

  // Occupancy next state from the input accept and output drain of this cycle
  always_comb begin
    occ_d = occ_q;
    case (occ_q)
      OCC_EMPTY: if (accept) occ_d = OCC_MAIN;
      OCC_MAIN: begin
        if (accept && !drain)      occ_d = OCC_BOTH;
        else if (!accept && drain) occ_d = OCC_EMPTY;
      end
      OCC_BOTH:  if (drain) occ_d = OCC_MAIN;
      default:   occ_d = OCC_EMPTY;
    endcase
  end

  // Handshake outputs and entry load strobes decoded from the occupancy state
  always_comb begin
    in_ready            = 1'b1;
    out_valid           = 1'b0;
    load_main_from_in   = 1'b0;
    load_main_from_skid = 1'b0;
    load_skid           = 1'b0;
    case (occ_q)
      OCC_EMPTY: begin
        load_main_from_in = accept;
      end
      OCC_MAIN: begin
        out_valid         = 1'b1;
        load_main_from_in = accept & drain;
        load_skid         = accept & ~drain;
      end
      OCC_BOTH: begin
        in_ready            = 1'b0;
        out_valid           = 1'b1;
        load_main_from_skid = drain;
      end
      default: begin
        in_ready = 1'b1;
      end
    endcase
  end

  // Main entry: refilled from the input or promoted from the skid entry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_data <= '0;
      main_req  <= '0;
    end else if (load_main_from_skid) begin
      main_data <= skid_data;
      main_req  <= skid_req;
    end else if (load_main_from_in) begin
      main_data <= routed_data;
      main_req  <= routed_req;
    end
  end

  // Skid entry: captures the packet accepted while the main entry is stalled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      skid_data <= '0;
      skid_req  <= '0;
    end else if (load_skid) begin
      skid_data <= routed_data;
      skid_req  <= routed_req;
    end
  end

  // Sticky malformed-hop flag; a new error outranks a clear in the same cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   err_hop <= 1'b0;
    else if (accept && hop_bad)  err_hop <= 1'b1;
    else if (err_clr)            err_hop <= 1'b0;
  end

  assign out_data = main_data;
  assign out_req  = out_valid ? main_req : 5'b00000;

`ifndef SYNTHESIS
  // A presented packet always carries exactly one output request
  a_req_onehot: assert property (@(posedge clk) disable iff (reset)
    out_valid |-> $onehot(out_req));

  // A stalled packet stays on the outputs unchanged until it is taken
  a_hold_stable: assert property (@(posedge clk) disable iff (reset)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_req)));
`endif

endmodule

// File: tb/tb_route_xy_stage.sv
// tb_route_xy_stage
// Drives two instances of route_xy_stage (thermometer and binary hop encoding)
// with identical traffic and compares them every cycle against a queue-based
// model of the routing rules, plus directed packets with hand-computed results.

module tb_route_xy_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [63:0] in_data;
  logic        out_ready;
  logic        err_clr;

  logic        in_ready,  out_valid,  err_hop;
  logic [63:0] out_data;
  logic [4:0]  out_req;

  logic        in_ready_b, out_valid_b, err_hop_b;
  logic [63:0] out_data_b;
  logic [4:0]  out_req_b;

  typedef struct packed {
    logic [63:0] d_therm;
    logic [63:0] d_bin;
    logic [4:0]  req;
  } entry_t;

  entry_t      model_q[$];
  entry_t      front;
  bit          err_exp;
  int          checks;
  int          failures;
  int          hs_count;
  int          stall_count;
  logic [3:0]  therm_vals [5] = '{4'd0, 4'd1, 4'd3, 4'd7, 4'd15};

  always #5 clk = ~clk;

  route_xy_stage #(.HOP_ENC(0)) u_dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_req(out_req), .err_hop(err_hop), .err_clr(err_clr)
  );

  route_xy_stage #(.HOP_ENC(1)) u_dut_bin (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
    .out_req(out_req_b), .err_hop(err_hop_b), .err_clr(err_clr)
  );

  // Expected result of routing one packet, for both hop encodings
  function automatic entry_t route_model(input logic [63:0] d);
    entry_t     e;
    logic [3:0] hx, hy;
    hx = d[55:52];
    hy = d[51:48];
    e.d_therm = d;
    e.d_bin   = d;
    if (hx != 0) begin
      e.req = d[62] ? 5'b01000 : 5'b00100;
      e.d_therm[55:52] = hx / 2;
      e.d_bin[55:52]   = hx - 1;
    end else if (hy != 0) begin
      e.req = d[61] ? 5'b00010 : 5'b00001;
      e.d_therm[51:48] = hy / 2;
      e.d_bin[51:48]   = hy - 1;
    end else begin
      e.req = 5'b10000;
    end
    return e;
  endfunction

  function automatic bit is_malformed(input logic [63:0] d);
    return !(d[55:52] inside {4'd0, 4'd1, 4'd3, 4'd7, 4'd15}) ||
           !(d[51:48] inside {4'd0, 4'd1, 4'd3, 4'd7, 4'd15});
  endfunction

  function automatic logic [63:0] rand_packet();
    logic [63:0] d;
    d = {$urandom, $urandom};
    if ($urandom_range(0, 3) != 0) d[55:52] = therm_vals[$urandom_range(0, 4)];
    if ($urandom_range(0, 3) != 0) d[51:48] = therm_vals[$urandom_range(0, 4)];
    return d;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Present one packet and hold it until the stage accepts it (returns at the accepting edge)
  task automatic applyStimulus(input logic [63:0] d);
    int waits;
    @(negedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = d;
    waits    = 0;
    while (!in_ready && waits < 50) begin
      @(negedge clk);
      #1;
      waits++;
      stall_count++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("[TB] FAIL accept_timeout actual=in_ready_low expected=accept_within_50_cycles");
    end
    @(posedge clk);
  endtask

  // Reference model: tracks buffered packets in order and the sticky error flag
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      model_q.delete();
      err_exp = 1'b0;
    end else begin
      bit acc, drn;
      acc = in_valid && (model_q.size() < 2);
      drn = (model_q.size() > 0) && out_ready;
      if (acc && is_malformed(in_data)) err_exp = 1'b1;
      else if (err_clr)                 err_exp = 1'b0;
      if (drn) begin
        void'(model_q.pop_front());
        hs_count++;
      end
      if (acc) model_q.push_back(route_model(in_data));
    end
  end

  // Compare both instances against the model on every falling edge
  always @(negedge clk) begin
    bit ev;
    ev = model_q.size() > 0;
    checkOutput("out_valid",   out_valid,   ev);
    checkOutput("in_ready",    in_ready,    model_q.size() < 2);
    checkOutput("err_hop",     err_hop,     err_exp);
    checkOutput("b_out_valid", out_valid_b, ev);
    checkOutput("b_in_ready",  in_ready_b,  model_q.size() < 2);
    checkOutput("b_err_hop",   err_hop_b,   1'b0);
    if (ev) begin
      front = model_q[0];
      checkOutput("out_data",   out_data,   front.d_therm);
      checkOutput("out_req",    out_req,    front.req);
      checkOutput("b_out_data", out_data_b, front.d_bin);
      checkOutput("b_out_req",  out_req_b,  front.req);
    end else begin
      checkOutput("out_req_idle",   out_req,   5'b00000);
      checkOutput("b_out_req_idle", out_req_b, 5'b00000);
    end
  end

  initial begin
    int hs0, st0;
    checks = 0; failures = 0; hs_count = 0; stall_count = 0;
    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; err_clr = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rst_out_valid", out_valid, 1'b0);
    checkOutput("rst_in_ready",  in_ready,  1'b1);
    checkOutput("rst_out_data",  out_data,  64'h0);
    checkOutput("rst_out_req",   out_req,   5'b00000);
    checkOutput("rst_err_hop",   err_hop,   1'b0);
    #1 reset = 1'b0;

    // East, hx 0011 -> 0001
    applyStimulus(64'h0033_1234_5678_9abc);
    @(negedge clk);
    checkOutput("t1_data", out_data, 64'h0013_1234_5678_9abc);
    checkOutput("t1_req",  out_req,  5'b00100);
    #1 in_valid = 1'b0;

    // South, hy 0011 -> 0001
    applyStimulus(64'h2003_1234_5678_9abc);
    @(negedge clk);
    checkOutput("t2_data", out_data, 64'h2001_1234_5678_9abc);
    checkOutput("t2_req",  out_req,  5'b00010);
    #1 in_valid = 1'b0;

    // PE, header unchanged
    applyStimulus(64'h0000_1234_5678_9abc);
    @(negedge clk);
    checkOutput("t2_pe_data", out_data, 64'h0000_1234_5678_9abc);
    checkOutput("t2_pe_req",  out_req,  5'b10000);
    #1 in_valid = 1'b0;

    // West, hx 0111 -> 0011
    applyStimulus(64'h4070_1234_5678_9abc);
    @(negedge clk);
    checkOutput("t3_w_data", out_data, 64'h4030_1234_5678_9abc);
    checkOutput("t3_w_req",  out_req,  5'b01000);
    #1 in_valid = 1'b0;

    // hx 0100: binary count 0011, thermometer shift 0010 and malformed
    applyStimulus(64'h0040_1234_5678_9abc);
    @(negedge clk);
    checkOutput("t3_bin_data", out_data_b, 64'h0030_1234_5678_9abc);
    checkOutput("t3_thm_data", out_data,   64'h0020_1234_5678_9abc);
    checkOutput("t3_err_set",  err_hop,    1'b1);
    #1 in_valid = 1'b0; err_clr = 1'b1;
    @(negedge clk);
    checkOutput("t3_err_clr", err_hop, 1'b0);

    // hx 0101 malformed while err_clr is held: setting wins
    applyStimulus(64'h0050_1234_5678_9abc);
    @(negedge clk);
    checkOutput("t3_bad_data", out_data, 64'h0020_1234_5678_9abc);
    checkOutput("t3_bad_req",  out_req,  5'b00100);
    checkOutput("t3_err_win",  err_hop,  1'b1);
    #1 in_valid = 1'b0;
    @(negedge clk);
    checkOutput("t3_err_clr2", err_hop, 1'b0);
    #1 err_clr = 1'b0;

    // Backpressure: two packets fill both entries, third waits
    out_ready = 1'b0;
    applyStimulus(64'h4010_0000_0000_0001);
    applyStimulus(64'h0001_0000_0000_0002);
    @(negedge clk);
    checkOutput("t4_in_ready", in_ready, 1'b0);
    checkOutput("t4_hold_p1",  out_data, 64'h4000_0000_0000_0001);
    fork
      applyStimulus(64'h0000_0000_0000_0003);
      begin
        repeat (3) @(negedge clk);
        #1 out_ready = 1'b1;
      end
    join
    @(negedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(negedge clk);

    // Streaming: 16 back-to-back packets must leave on 16 consecutive edges
    #1;
    hs0 = hs_count;
    st0 = stall_count;
    for (int i = 0; i < 16; i++) applyStimulus(rand_packet());
    @(negedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("t5_stream_count",  hs_count - hs0,    16);
    checkOutput("t5_stream_stalls", stall_count - st0, 0);

    // Random traffic with random backpressure and clears
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = rand_packet();
      out_ready = ($urandom_range(0, 2) != 0);
      err_clr   = ($urandom_range(0, 7) == 0);
    end
    @(negedge clk);
    #1 in_valid = 1'b0; out_ready = 1'b1; err_clr = 1'b0;
    repeat (4) @(negedge clk);

    // Reset while both entries are full and the error flag is set
    #1 out_ready = 1'b0;
    applyStimulus(64'h0050_0000_0000_00aa);
    applyStimulus(64'h0003_0000_0000_00bb);
    @(negedge clk);
    checkOutput("t6_full",    in_ready, 1'b0);
    checkOutput("t6_err_pre", err_hop,  1'b1);
    #1 in_valid = 1'b0;
    #1 reset = 1'b1;
    #1;
    checkOutput("t6_out_valid", out_valid, 1'b0);
    checkOutput("t6_in_ready",  in_ready,  1'b1);
    checkOutput("t6_err_hop",   err_hop,   1'b0);
    checkOutput("t6_out_req",   out_req,   5'b00000);
    @(negedge clk);
    #1 reset = 1'b0; out_ready = 1'b1;
    applyStimulus(64'h0033_1234_5678_9abc);
    @(negedge clk);
    checkOutput("t6_after_data", out_data, 64'h0013_1234_5678_9abc);
    checkOutput("t6_after_req",  out_req,  5'b00100);
    #1 in_valid = 1'b0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
